// File: rtl/decoder_pkg.sv
// Shared definitions for the registered N-to-2^N decoder: mode codes,
// FSM state type, counter widths and the one-hot helper.
// Items: MODE_* constants, state_t, PULSE_CNT_W/SCAN_CNT_W, onehot().
package decoder_pkg;

  // Mode input encoding
  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_PULSE = 2'd1;
  localparam logic [1:0] MODE_SCAN  = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

  // Counter widths cover the legal parameter ranges (PULSE_LEN<=255, SCAN_DIV<=65535)
  localparam int unsigned PULSE_CNT_W = 8;
  localparam int unsigned SCAN_CNT_W  = 16;

  // onehot() works on the widest supported decoder; callers size-cast
  // the result down to their own OUT_W.
  localparam int unsigned ONEHOT_SEL_MAX_W = 8;
  localparam int unsigned ONEHOT_MAX_W     = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2,
    SCAN  = 2'd3
  } state_t;

  // One-hot decode of sel; any index at or beyond out_w yields all zeros,
  // so an out-of-range value can never light an output.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(
    input logic [ONEHOT_SEL_MAX_W-1:0] sel,
    input int unsigned                 out_w
  );
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    if (32'(sel) < out_w) v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_step_timer.sv
// Loadable down-counter with a "last cycle" flag.
// Latency: load/decrement take effect on the next clk edge; o_done is combinational from the count.
// Backpressure: none; i_en low freezes the count.
// Ports: clk, rst_n, i_en (freeze when 0), i_load/i_load_val (reload),
//        i_dec (decrement, saturates at 0), o_done (count is 1 or 0).
module decoder_step_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Done marks the final counted cycle, so the owner acts on this edge and
  // a load value of N spans exactly N cycles.
  assign o_done = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/decoder_nx2n_reg.sv
// Registered N-to-2^N one-hot decoder with hold, timed-pulse and scan modes.
// Latency: one clk from accept (or mode change) to y; y is a pure register output.
// Backpressure: in_ready high only in IDLE/HOLD with mode hold/pulse and en=1; low during pulse/scan.
// Ports: clk, rst_n (async active-low), en (freeze), mode[1:0], in_valid/in_ready/sel
//        (select handshake), y[2**SEL_W-1:0] (one-hot), busy (pulse or scan active).
// Build option: define DECODER_ACTIVE_LOW_EN to emit y inverted (idle/reset = all ones).
module decoder_nx2n_reg
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned SCAN_DIV  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [(2**SEL_W)-1:0]   y,
  output logic                    busy
);

  localparam int unsigned OUT_W = 2**SEL_W;

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_idx, w_idx_nxt;
  logic             r_rdy, w_rdy_nxt;
  logic [OUT_W-1:0] r_y, w_y_nxt, w_y_out;

  logic w_acc;
  logic w_pls_load, w_pls_dec, w_pls_done;
  logic w_div_load, w_div_dec, w_div_done;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] Y_RST = '1;
  assign w_y_out = ~w_y_nxt;
`else
  localparam logic [OUT_W-1:0] Y_RST = '0;
  assign w_y_out = w_y_nxt;
`endif

  // r_rdy tracks the state; mode and en gate it so a scan/off request or a
  // freeze never lets an accept slip through.
  assign in_ready = r_rdy & en & ((mode == MODE_HOLD) || (mode == MODE_PULSE));
  assign w_acc    = in_valid & in_ready;
  assign busy     = (r_state == PULSE) || (r_state == SCAN);
  assign y        = r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_idx   <= '0;
      r_rdy   <= 1'b0;
      r_y     <= Y_RST;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_idx   <= w_idx_nxt;
      r_rdy   <= w_rdy_nxt;
      r_y     <= w_y_out;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_idx_nxt   = r_idx;
    w_pls_load  = 1'b0;
    w_pls_dec   = 1'b0;
    w_div_load  = 1'b0;
    w_div_dec   = 1'b0;

    case (r_state)
      IDLE, HOLD: begin
        if (mode == MODE_SCAN) begin
          w_state_nxt = SCAN;
          w_idx_nxt   = '0;
          w_div_load  = 1'b1;
        end else if (mode == MODE_OFF) begin
          w_state_nxt = IDLE;
        end else if (w_acc) begin
          w_sel_nxt = sel;
          if (mode == MODE_PULSE) begin
            w_state_nxt = PULSE;
            w_pls_load  = 1'b1;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      PULSE: begin
        // Mode and input are ignored until the pulse has run its full length.
        w_pls_dec = 1'b1;
        if (w_pls_done) w_state_nxt = IDLE;
      end
      SCAN: begin
        if (mode != MODE_SCAN) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else if (w_div_done) begin
          w_idx_nxt  = r_idx + SEL_W'(1);
          w_div_load = 1'b1;
        end else begin
          w_div_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    w_rdy_nxt = (w_state_nxt == IDLE) || (w_state_nxt == HOLD);

    // y is decoded from the next-state values so it lands with the state.
    case (w_state_nxt)
      HOLD, PULSE: w_y_nxt = OUT_W'(onehot(ONEHOT_SEL_MAX_W'(w_sel_nxt), OUT_W));
      SCAN:        w_y_nxt = OUT_W'(onehot(ONEHOT_SEL_MAX_W'(w_idx_nxt), OUT_W));
      default:     w_y_nxt = '0;
    endcase
  end

  decoder_step_timer #(.CNT_W(PULSE_CNT_W)) u_pulse_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_load     (w_pls_load),
    .i_load_val (PULSE_CNT_W'(PULSE_LEN)),
    .i_dec      (w_pls_dec),
    .o_done     (w_pls_done)
  );

  decoder_step_timer #(.CNT_W(SCAN_CNT_W)) u_scan_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_load     (w_div_load),
    .i_load_val (SCAN_CNT_W'(SCAN_DIV)),
    .i_dec      (w_div_dec),
    .o_done     (w_div_done)
  );

endmodule

// File: tb/tb_decoder_nx2n_reg.sv
// Self-checking bench for decoder_nx2n_reg (SEL_W=2, PULSE_LEN=4, SCAN_DIV=2).
// Vector table covers hold/pulse/scan; hand sequences cover freeze and async reset.
// Expected outputs go through a scoreboard queue, compared 1 time unit after each clk edge.
module tb_decoder_nx2n_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [3:0] y;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       vld;
    logic [1:0] sel;
    logic [3:0] y;
    logic       rdy;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] y;
    logic       rdy;
    logic       busy;
    string      nm;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[23];

  always #5 clk = ~clk;

  decoder_nx2n_reg #(.SEL_W(2), .PULSE_LEN(4), .SCAN_DIV(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .y        (y),
    .busy     (busy)
  );

  function automatic logic [3:0] ye(input logic [3:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic vec_t mk(input logic e, input logic [1:0] m, input logic v,
                              input logic [1:0] s, input logic [3:0] ey,
                              input logic er, input logic eb);
    vec_t r;
    r.en = e; r.mode = m; r.vld = v; r.sel = s; r.y = ey; r.rdy = er; r.busy = eb;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: queue empty at t=%0t", $time);
    end else begin
      e = sb.pop_front();
      cmp({e.nm, ".y"}, y, e.y);
      cmp({e.nm, ".in_ready"}, {3'b0, in_ready}, {3'b0, e.rdy});
      cmp({e.nm, ".busy"}, {3'b0, busy}, {3'b0, e.busy});
    end
  endtask

  task automatic expect_now(input logic [3:0] ey, input logic er, input logic eb, input string nm);
    exp_t e;
    e.y = ye(ey); e.rdy = er; e.busy = eb; e.nm = nm;
    sb.push_back(e);
    check_out();
  endtask

  // Called at a negedge: drive, wait for the edge, check, return at next negedge.
  task automatic step(input logic e, input logic [1:0] m, input logic v, input logic [1:0] s,
                      input logic [3:0] ey, input logic er, input logic eb, input string nm);
    exp_t x;
    en = e; mode = m; in_valid = v; sel = s;
    x.y = ye(ey); x.rdy = er; x.busy = eb; x.nm = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hold mode (test 1)
    tbl[0]  = mk(1, 0, 0, 0, 4'b0000, 1, 0); // first edge after release: ready rises
    tbl[1]  = mk(1, 0, 1, 2, 4'b0100, 1, 0);
    tbl[2]  = mk(1, 0, 1, 0, 4'b0001, 1, 0); // back-to-back accept
    tbl[3]  = mk(1, 0, 0, 3, 4'b0001, 1, 0); // no valid: held
    tbl[4]  = mk(1, 0, 0, 3, 4'b0001, 1, 0);
    // Pulse mode (test 2)
    tbl[5]  = mk(1, 1, 0, 0, 4'b0001, 1, 0); // mode 1 without accept stays HOLD
    tbl[6]  = mk(1, 1, 1, 3, 4'b1000, 0, 1); // pulse cycle 1
    tbl[7]  = mk(1, 1, 1, 1, 4'b1000, 0, 1); // valid ignored mid-pulse
    tbl[8]  = mk(1, 1, 1, 1, 4'b1000, 0, 1);
    tbl[9]  = mk(1, 3, 0, 0, 4'b1000, 0, 1); // mode 3 ignored mid-pulse, cycle 4
    tbl[10] = mk(1, 1, 0, 0, 4'b0000, 1, 0); // pulse over
    // Scan mode (test 3)
    tbl[11] = mk(1, 2, 0, 0, 4'b0001, 0, 1);
    tbl[12] = mk(1, 2, 0, 0, 4'b0001, 0, 1);
    tbl[13] = mk(1, 2, 0, 0, 4'b0010, 0, 1);
    tbl[14] = mk(1, 2, 0, 0, 4'b0010, 0, 1);
    tbl[15] = mk(1, 2, 0, 0, 4'b0100, 0, 1);
    tbl[16] = mk(1, 2, 0, 0, 4'b0100, 0, 1);
    tbl[17] = mk(1, 2, 0, 0, 4'b1000, 0, 1);
    tbl[18] = mk(1, 2, 0, 0, 4'b1000, 0, 1);
    tbl[19] = mk(1, 2, 0, 0, 4'b0001, 0, 1); // wrap
    tbl[20] = mk(1, 2, 0, 0, 4'b0001, 0, 1);
    tbl[21] = mk(1, 3, 0, 0, 4'b0000, 0, 0); // off
    tbl[22] = mk(1, 0, 0, 0, 4'b0000, 1, 0);

    rst_n = 1'b1; en = 1'b1; mode = 2'd0; in_valid = 1'b0; sel = 2'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    expect_now(4'b0000, 0, 0, "reset");
    rst_n = 1'b1;
    #1;
    expect_now(4'b0000, 0, 0, "release_before_edge");

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].en, tbl[i].mode, tbl[i].vld, tbl[i].sel,
           tbl[i].y, tbl[i].rdy, tbl[i].busy, $sformatf("vec%0d", i));
    end

    // Freeze mid-scan at y=0010 (test 4)
    step(1, 2, 0, 0, 4'b0001, 0, 1, "frz_scan0");
    step(1, 2, 0, 0, 4'b0001, 0, 1, "frz_scan1");
    step(1, 2, 0, 0, 4'b0010, 0, 1, "frz_scan2");
    for (int i = 0; i < 5; i++) step(0, 2, 0, 0, 4'b0010, 0, 1, $sformatf("frozen%0d", i));
    step(1, 2, 0, 0, 4'b0010, 0, 1, "resume0");
    step(1, 2, 0, 0, 4'b0100, 0, 1, "resume1");
    step(1, 2, 0, 0, 4'b0100, 0, 1, "resume2");
    step(1, 2, 0, 0, 4'b1000, 0, 1, "resume3");
    step(1, 3, 0, 0, 4'b0000, 0, 0, "scan_off");
    // Freeze in HOLD blocks accepts
    step(1, 0, 1, 1, 4'b0010, 1, 0, "hold_sel1");
    step(0, 0, 1, 3, 4'b0010, 0, 0, "hold_frozen");
    step(1, 0, 0, 3, 4'b0010, 1, 0, "hold_thaw");

    // Asynchronous reset mid-pulse (test 5)
    step(1, 1, 1, 2, 4'b0100, 0, 1, "pulse_start");
    step(1, 1, 0, 0, 4'b0100, 0, 1, "pulse_mid");
    #2 rst_n = 1'b0;
    #1;
    expect_now(4'b0000, 0, 0, "async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0, 4'b0000, 1, 0, "post_reset_edge1");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 4'b0000, 1, 0, $sformatf("no_residual%0d", i));

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_nx2n_reg.md
Name: decoder_nx2n_reg

Overview:
Parametrised, registered N-to-2^N one-hot decoder/demultiplexer. Generalises the 1-to-2 gate-level decoder to SEL_W select bits.
- Adds a valid/ready input handshake.
- Adds three output modes: hold, timed pulse, and free-running scan.
- Sits between control logic and banks of enables (LED/segment drivers, chip selects, demux strobes).

Parameters:
SEL_W, 2, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable)
PULSE_LEN, 4, cycles a one-hot output stays asserted in pulse mode; legal range 1..255
SCAN_DIV, 1, clock cycles per scan step in scan mode; legal range 1..65535

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; 0 freezes state, counters and outputs
mode  in  2  0=hold, 1=pulse, 2=scan, 3=off
in_valid  in  1  sel presented
in_ready  out  1  block can accept sel this cycle
sel  in  SEL_W  index to decode
y  out  OUT_W  registered one-hot (or all-zero) output
busy  out  1  pulse in progress or scan running

Behaviour:
- One clock (clk), asynchronous active-low reset (rst_n); all state flops reset asynchronously, release synchronous to clk.
- Reset values: y=0, in_ready=0, busy=0, state=IDLE, pulse counter=0, scan index=0, divider=0. in_ready rises the first clk edge after reset release.
- Accept = in_valid & in_ready at a rising edge.
- State machine:
  - IDLE: y=0, in_ready=1 (mode 0/1). mode 0 accept -> HOLD. mode 1 accept -> PULSE. mode 2 -> SCAN regardless of input.
  - HOLD: y=onehot(sel_latched); in_ready=1. A new accept updates y the next cycle (latency 1, back-to-back accepts allowed every cycle). Mode change to 3 -> IDLE. Mode change to 2 -> SCAN. Mode change to 1 -> stays HOLD until the next accept, which enters PULSE.
  - PULSE: y=onehot(sel_latched) for exactly PULSE_LEN cycles, counted from the cycle after accept; then y=0 and -> IDLE. in_ready=0 and busy=1 throughout. Input ignored; a mode change mid-pulse is not honoured until the pulse completes.
  - SCAN: y=onehot(idx); idx increments every SCAN_DIV cycles and wraps OUT_W-1 -> 0. in_ready=0, busy=1. Leaving mode 2 -> IDLE next cycle, y=0, idx reset to 0.
- mode=3 from any state except PULSE: -> IDLE next cycle, y=0.
- en=0: no state, counter, idx or y change; in_ready forced 0. Resume exactly where frozen.
- y is never multi-hot. Any out-of-range internal value forces y=0.
- Reset asserted mid-pulse or mid-scan: immediate clear to reset values; no partial output afterwards.
- sel is always in range (2**SEL_W codes); no error path.

Optional Feature:
DECODER_ACTIVE_LOW_EN
- Defined: y is emitted inverted (active-low one-hot, idle = all ones, reset value all ones), matching NOR/NAND-style active-low enable banks. Internal logic unchanged; inversion is the last register stage, so latency is unchanged.
- Undefined: active-high as described above.

Decomposition:
- Shared package decoder_pkg:
  - mode encoding constants: MODE_HOLD=2'd0, MODE_PULSE=2'd1, MODE_SCAN=2'd2, MODE_OFF=2'd3
  - state enum typedef: IDLE, HOLD, PULSE, SCAN
  - function onehot(sel) returning OUT_W bits
- One sub-module, decoder_step_timer: loadable down-counter with a done flag, instanced twice — pulse length (load PULSE_LEN) and scan divider (load SCAN_DIV).

Test Plan:
1. SEL_W=2, mode 0, reset release, accept sel=2 -> y=4'b0100 one cycle later, held. Accept sel=0 next cycle -> y=4'b0001.
2. mode 1, PULSE_LEN=4, accept sel=3 -> y=4'b1000 for exactly 4 cycles, in_ready=0 and busy=1 throughout, then y=0 and in_ready=1. in_valid held high mid-pulse is ignored.
3. mode 2, SCAN_DIV=2 -> y sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001 (wrap). Switch to mode 3 -> y=0 next cycle.
4. en=0 mid-scan at y=0010 for 5 cycles -> y frozen at 0010. en=1 -> sequence resumes at the frozen point.
5. rst_n low asynchronously (between edges) mid-pulse -> y=0 immediately. After release, in_ready=1 on the first edge and no residual pulse.
6. With DECODER_ACTIVE_LOW_EN, rerun test 1 -> reset y=4'b1111, sel=2 gives y=4'b1011.
